// File: rtl/bullet_engine_if.sv
// Signal bundle between the game controller and bullet_engine: controls,
// ship/enemy positions in, bullet state, hit pulse and score out.
interface bullet_engine_if;
  logic        frame_tick;
  logic        start_game;
  logic        finish_game;
  logic [5:0]  bullet_status;
  logic [9:0]  ship_x;
  logic [9:0]  ship_y;
  logic [9:0]  enemy_x;
  logic [9:0]  enemy_y;
  logic [5:0]  bullet_active;
  logic [59:0] bullet_x;
  logic [59:0] bullet_y;
  logic        collision;
  logic [3:0]  counter_sum;

  modport master (
    output frame_tick, start_game, finish_game, bullet_status,
           ship_x, ship_y, enemy_x, enemy_y,
    input  bullet_active, bullet_x, bullet_y, collision, counter_sum
  );

  modport slave (
    input  frame_tick, start_game, finish_game, bullet_status,
           ship_x, ship_y, enemy_x, enemy_y,
    output bullet_active, bullet_x, bullet_y, collision, counter_sum
  );
endinterface

// File: rtl/bullet_engine.sv
// Six independent bullet slots: launch from the ship on a fire edge, rise per
// frame, retire at the top edge or on an enemy hit, and keep a saturating score.
module bullet_engine #(
  parameter int BULLET_SPEED = 4,
  parameter int HIT_HALF     = 16,
  parameter int SCORE_MAX    = 15
) (
  input logic             clk,
  input logic             reset,
  bullet_engine_if.slave  bus
);
  localparam int          N_SLOT  = 6;
  localparam logic [9:0]  SPEED_V = 10'(BULLET_SPEED);
  localparam logic [10:0] HALF_V  = 11'(HIT_HALF);
  localparam logic [3:0]  SMAX_V  = 4'(SCORE_MAX);

  logic [5:0] status_q, status_d;
  logic [5:0] active_q, active_d;
  logic [9:0] x_q [N_SLOT];
  logic [9:0] x_d [N_SLOT];
  logic [9:0] y_q [N_SLOT];
  logic [9:0] y_d [N_SLOT];
  logic       collision_q, collision_d;
  logic [3:0] score_q, score_d;

  logic [5:0]  rise;
  logic [5:0]  hit_vec;
  logic [59:0] x_flat;
  logic [59:0] y_flat;

  assign rise = bus.bullet_status & ~status_q;

  // Differences are taken one bit wider so the sign survives and the magnitude never wraps.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      logic [10:0] dx, dy, adx, ady;
      dx  = {1'b0, x_q[i]} - {1'b0, bus.enemy_x};
      dy  = {1'b0, y_q[i]} - {1'b0, bus.enemy_y};
      adx = dx[10] ? -dx : dx;
      ady = dy[10] ? -dy : dy;
      hit_vec[i] = active_q[i] && (adx <= HALF_V) && (ady <= HALF_V);
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default up front so no path can infer a latch.
    status_d    = bus.bullet_status;
    active_d    = active_q;
    x_d         = x_q;
    y_d         = y_q;
    collision_d = 1'b0;
    score_d     = score_q;

    if (bus.finish_game) begin
      // Frozen: everything holds.
    end else if (!bus.start_game) begin
      active_d = '0;
      score_d  = '0;
    end else begin
      for (int i = 0; i < N_SLOT; i++) begin
        if (rise[i] && !active_q[i]) begin
          active_d[i] = 1'b1;
          x_d[i]      = bus.ship_x;
          y_d[i]      = bus.ship_y;
        end else if (bus.frame_tick && active_q[i]) begin
          if (hit_vec[i]) begin
            active_d[i] = 1'b0;
          end else if (y_q[i] > SPEED_V) begin
            y_d[i] = y_q[i] - SPEED_V;
          end else begin
            active_d[i] = 1'b0;
          end
        end
      end
      if (bus.frame_tick && (|hit_vec)) begin
        collision_d = 1'b1;
        if (score_q < SMAX_V) score_d = score_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q    <= '0;
      active_q    <= '0;
      collision_q <= 1'b0;
      score_q     <= '0;
      // NOTE: position arrays are reset too, because they drive outputs that must read 0 in reset.
      for (int i = 0; i < N_SLOT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      status_q    <= status_d;
      active_q    <= active_d;
      collision_q <= collision_d;
      score_q     <= score_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  always_comb begin
    x_flat = '0;
    y_flat = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      x_flat[10*i +: 10] = x_q[i];
      y_flat[10*i +: 10] = y_q[i];
    end
  end

  assign bus.bullet_active = active_q;
  assign bus.bullet_x      = x_flat;
  assign bus.bullet_y      = y_flat;
  assign bus.collision     = collision_q;
  assign bus.counter_sum   = score_q;
endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine: stimulus pushes expected values stamped
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_bullet_engine;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  bullet_engine_if bus ();

  bullet_engine #(.BULLET_SPEED(4), .HIT_HALF(16), .SCORE_MAX(15)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {F_ACT, F_X, F_Y, F_COLL, F_SCORE} field_e;
  typedef struct {
    string  name;
    int     cyc;
    field_e fld;
    int     slot;
    int     val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic int actual(field_e f, int slot);
    case (f)
      F_ACT:   return int'(bus.bullet_active);
      F_X:     return int'(bus.bullet_x[10*slot +: 10]);
      F_Y:     return int'(bus.bullet_y[10*slot +: 10]);
      F_COLL:  return int'(bus.collision);
      default: return int'(bus.counter_sum);
    endcase
  endfunction

  // Monitor: compares every expectation due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = actual(e.fld, e.slot);
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: sample missed, due cycle %0d, now %0d", e.name, e.cyc, cyc);
      end else if (a != e.val) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.val, cyc);
      end
    end
  end

  task automatic chk(input string name, input field_e f, input int slot, input int val);
    exp_t e;
    e.name = name; e.cyc = cyc; e.fld = f; e.slot = slot; e.val = val;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulse(input int slot);
    bus.bullet_status[slot] = 1'b1;
    step();
    bus.bullet_status[slot] = 1'b0;
  endtask

  task automatic ship(input int x, input int y);
    bus.ship_x = 10'(x);
    bus.ship_y = 10'(y);
  endtask

  task automatic enemy(input int x, input int y);
    bus.enemy_x = 10'(x);
    bus.enemy_y = 10'(y);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.frame_tick    = 1'b0;
    bus.start_game    = 1'b0;
    bus.finish_game   = 1'b0;
    bus.bullet_status = 6'b000001;
    ship(0, 0);
    enemy(1000, 1000);

    // Reset state
    step(); step();
    chk("rst_act", F_ACT, 0, 0);
    chk("rst_x0", F_X, 0, 0);
    chk("rst_y0", F_Y, 0, 0);
    chk("rst_coll", F_COLL, 0, 0);
    chk("rst_score", F_SCORE, 0, 0);
    step();

    // Held fire request with the game not started: no launch
    rst_n = 1'b1;
    step();
    chk("nostart_act", F_ACT, 0, 0);
    step();

    // Held fire request with the game running: slot 0 launches after reset
    rst_n = 1'b0;
    bus.start_game = 1'b1;
    ship(100, 400);
    step();
    chk("rst2_act", F_ACT, 0, 0);
    rst_n = 1'b1;
    step();
    chk("launch_act", F_ACT, 0, 1);
    chk("launch_x0", F_X, 0, 100);
    chk("launch_y0", F_Y, 0, 400);
    bus.bullet_status = 6'b0;
    step();

    // Three frames of flight
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fly_coll", F_COLL, 0, 0);
      step();
    end
    chk("fly_act", F_ACT, 0, 1);
    chk("fly_x0", F_X, 0, 100);
    chk("fly_y0", F_Y, 0, 388);

    // Refire while in flight is ignored
    ship(300, 300);
    pulse(0);
    chk("retrig_act", F_ACT, 0, 1);
    chk("retrig_x0", F_X, 0, 100);
    chk("retrig_y0", F_Y, 0, 388);
    step();

    // Top exit on slot 2
    ship(200, 6);
    pulse(2);
    chk("top_act", F_ACT, 0, 5);
    chk("top_x2", F_X, 2, 200);
    chk("top_y2", F_Y, 2, 6);
    step();
    tick();
    chk("top1_y2", F_Y, 2, 2);
    chk("top1_act", F_ACT, 0, 5);
    chk("top1_y0", F_Y, 0, 384);
    chk("top1_coll", F_COLL, 0, 0);
    step();
    tick();
    chk("top2_act", F_ACT, 0, 1);
    chk("top2_y2", F_Y, 2, 2);
    chk("top2_coll", F_COLL, 0, 0);
    step();

    // Dropping start_game clears slots and score
    bus.start_game = 1'b0;
    step();
    chk("clr_act", F_ACT, 0, 0);
    chk("clr_score", F_SCORE, 0, 0);
    bus.start_game = 1'b1;
    step();

    // Single hit
    enemy(100, 380);
    ship(110, 390);
    pulse(0);
    chk("hit_launch", F_ACT, 0, 1);
    step();
    tick();
    chk("hit_coll", F_COLL, 0, 1);
    chk("hit_act", F_ACT, 0, 0);
    chk("hit_y0", F_Y, 0, 390);
    chk("hit_score", F_SCORE, 0, 1);
    step();
    chk("hit_pulse_end", F_COLL, 0, 0);

    // Two hits exactly on the box edge plus a miss one pixel outside
    ship(116, 380); pulse(0); step();
    ship(84, 396);  pulse(1); step();
    ship(117, 380); pulse(2); step();
    chk("multi_launch", F_ACT, 0, 7);
    tick();
    chk("multi_act", F_ACT, 0, 4);
    chk("multi_coll", F_COLL, 0, 1);
    chk("multi_score", F_SCORE, 0, 2);
    chk("multi_y2", F_Y, 2, 376);
    step();
    chk("multi_pulse_end", F_COLL, 0, 0);
    chk("multi_score2", F_SCORE, 0, 2);

    // Score climbs to 15 and saturates
    for (int k = 3; k <= 16; k++) begin
      ship(100, 380);
      pulse(0);
      step();
      tick();
      chk("sat_score", F_SCORE, 0, (k > 15) ? 15 : k);
      chk("sat_coll", F_COLL, 0, 1);
      chk("sat_act", F_ACT, 0, 4);
      step();
    end
    chk("sat_y2", F_Y, 2, 320);

    // Freeze
    bus.finish_game = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_y2", F_Y, 2, 320);
      chk("frz_x2", F_X, 2, 117);
      chk("frz_act", F_ACT, 0, 4);
      chk("frz_coll", F_COLL, 0, 0);
      chk("frz_score", F_SCORE, 0, 15);
      step();
    end
    pulse(3);
    chk("frz_nolaunch", F_ACT, 0, 4);
    step();
    bus.finish_game = 1'b0;
    step();

    // Launch coinciding with frame_tick on slot 4
    enemy(1000, 1000);
    ship(500, 600);
    bus.bullet_status[4] = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    bus.bullet_status[4] = 1'b0;
    bus.frame_tick = 1'b0;
    chk("co_act", F_ACT, 0, 20);
    chk("co_x4", F_X, 4, 500);
    chk("co_y4", F_Y, 4, 600);
    chk("co_y2", F_Y, 2, 316);
    chk("co_coll", F_COLL, 0, 0);
    step();

    // start_game falls on a hitting frame: clear wins, no pulse
    enemy(500, 600);
    bus.start_game = 1'b0;
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    chk("drop_act", F_ACT, 0, 0);
    chk("drop_score", F_SCORE, 0, 0);
    chk("drop_coll", F_COLL, 0, 0);
    step();
    chk("drop_coll2", F_COLL, 0, 0);
    bus.start_game = 1'b1;
    step();

    // Asynchronous reset mid-flight
    ship(50, 50);
    pulse(3);
    chk("pre_ar_act", F_ACT, 0, 8);
    chk("pre_ar_x3", F_X, 3, 50);
    step();
    rst_n = 1'b0;
    chk("ar_act", F_ACT, 0, 0);
    chk("ar_x3", F_X, 3, 0);
    chk("ar_y3", F_Y, 3, 0);
    chk("ar_score", F_SCORE, 0, 0);
    step();
    rst_n = 1'b1;
    step(); step();

    if (sb.size() != 0) begin
      bad += sb.size();
      total += sb.size();
      $display("FAIL pending: %0d expectations never compared", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bullet_engine.md
BULLET_ENGINE -- requirements
Module: bullet_engine

Interface
REQ-001 Parameter BULLET_SPEED, default 4: pixels a bullet rises per frame_tick.
REQ-002 Parameter HIT_HALF, default 16: half-width and half-height of the enemy hitbox, in pixels.
REQ-003 Parameter SCORE_MAX, default 15: saturation value of counter_sum.
REQ-004 clk  in  1  system clock; one clock domain; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously with clk.
REQ-006 frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-007 start_game  in  1  high while the game is in progress.
REQ-008 finish_game  in  1  high while the game is over.
REQ-009 bullet_status  in  6  per-slot fire request from the game controller.
REQ-010 ship_x, ship_y  in  10 each  player ship muzzle position.
REQ-011 enemy_x, enemy_y  in  10 each  enemy centre position.
REQ-012 bullet_active  out  6  slot i is in flight.
REQ-013 bullet_x, bullet_y  out  60 each  packed positions; slot i occupies bits [10i+9:10i].
REQ-014 collision  out  1  one-cycle hit pulse.
REQ-015 counter_sum  out  4  hit score.

Function
REQ-016 Each slot SHALL have two states, IDLE and FLIGHT, held in bullet_active[i].
- IDLE -> FLIGHT (launch): rising edge of bullet_status[i], detected against a registered copy, while start_game=1 and finish_game=0.
- On launch, x <= ship_x and y <= ship_y.
REQ-017 A rising edge on bullet_status[i] while slot i is in FLIGHT SHALL be ignored. There is no retrigger and no queueing.
REQ-018 On frame_tick, each FLIGHT slot that is not launching SHALL behave as follows:
- y > BULLET_SPEED: y <= y - BULLET_SPEED.
- Otherwise: the slot returns to IDLE with y unchanged. No underflow or wrap is permitted.
REQ-019 The x coordinate of a slot SHALL NOT change while in FLIGHT.
REQ-020 Hit test: slot i hits when all of the following hold, using pre-move registered coordinates:
- the slot is in FLIGHT;
- |x-enemy_x| <= HIT_HALF and |y-enemy_y| <= HIT_HALF, computed with 11-bit unsigned-safe differences.
REQ-021 Hits SHALL be evaluated only on frame_tick.
- Every hitting slot returns to IDLE instead of moving.
- collision pulses high for exactly one cycle, the cycle after the frame_tick.
REQ-022 counter_sum SHALL increment by 1 per frame_tick with at least one hit, regardless of the number of simultaneous hits. It saturates at SCORE_MAX and never wraps.
REQ-023 If launch and frame_tick coincide on slot i, the launch SHALL take priority: the slot loads the ship position, with no move and no hit test that cycle.
REQ-024 While finish_game=1, the block SHALL freeze. Positions, bullet_active and counter_sum hold; no launches, moves, hits or collision pulses occur.
REQ-025 While start_game=0 (and finish_game=0), all slots SHALL be IDLE and counter_sum SHALL be 0, applied synchronously. This takes priority over launch and frame_tick.
REQ-026 If start_game falls mid-flight, all slots SHALL clear on the next clk edge, and any pending collision pulse SHALL be suppressed.
REQ-027 Slots SHALL be fully independent; up to 6 bullets may be in flight simultaneously.
REQ-028 Output latency: bullet_active and positions SHALL update 1 cycle after the causing edge, and collision 1 cycle after frame_tick.

Reset
REQ-029 While reset=0, all outputs SHALL be 0 and the bullet_status edge register SHALL be 0.
REQ-030 After reset deassertion, an input already held at bullet_status=6'b000001 SHALL launch slot 0 only if start_game=1 and finish_game=0.
REQ-031 Assertion of reset mid-flight SHALL clear everything asynchronously, without waiting for a clk edge.

Verification
REQ-032 Launch and fly:
- Stimulus: start_game=1; ship=(100,400); pulse bullet_status[0]; then 3 frame_ticks.
- Response: bullet_active=6'b000001, bullet_x[9:0]=100, bullet_y[9:0]=388.
REQ-033 Top exit:
- Stimulus: launch slot 2 at y=6, then 2 frame_ticks.
- Response: y=2 after the first tick; slot 2 IDLE after the second tick; no collision.
REQ-034 Hit and score:
- Stimulus: enemy=(100,380); bullet at (110,390); frame_tick.
- Response: collision high 1 cycle, slot IDLE, counter_sum 0->1.
REQ-035 Simultaneous hits:
- Stimulus: slots 0 and 1 both inside the hitbox on one frame_tick.
- Response: both IDLE, one collision pulse, counter_sum +1.
REQ-036 Saturation and freeze:
- Stimulus: counter_sum=15, then another hit.
- Response: counter_sum stays 15.
- Stimulus: finish_game=1 with 3 frame_ticks.
- Response: positions unchanged.
REQ-037 Launch/tick collision and clear:
- Stimulus: bullet_status edge on slot 4 in the same cycle as frame_tick.
- Response: slot 4 loads the ship position, unmoved.
- Stimulus: drop start_game.
- Response: bullet_active=0 and counter_sum=0 next cycle.
